// File: rtl/pool_if.sv
// Handshake bundle for pool_ctrl: job control, pixel input stream, pooled result stream.
// The master modport drives jobs and pixels; the slave modport is the controller side.
interface pool_if #(
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_ch;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, done, in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/pool_ctrl.sv
// pool_ctrl: averages CHANNELS consecutive 8x8 windows (64 beats each) from a pixel stream
// and emits one result per channel on a valid/ready output.
// Optional macro POOL_ROUND_EN: round-half-up ((sum + 32) >> 6) instead of truncation.
module pool_ctrl #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DATA_W   = 16
) (
  input logic   clk,
  input logic   rst,
  pool_if.slave bus
);

  localparam int unsigned AccW   = DATA_W + 6;
  localparam logic [7:0]  LastCh = 8'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StOut, StDone} state_e;

  state_e            state_q;
  logic [AccW-1:0]   acc_q;
  logic [5:0]        cnt_q;
  logic [7:0]        ch_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q, done_q, in_ready_q, out_valid_q;

  logic [AccW-1:0]   acc_sum;
  logic [AccW-1:0]   acc_rnd;
  logic [DATA_W-1:0] avg;

  // Running sum including the beat currently offered, and its scaled average.
  // 64 * max pixel + 32 still fits in AccW bits, so neither add can wrap.
  always_comb begin
    acc_sum = acc_q + AccW'(bus.in_data);
`ifdef POOL_ROUND_EN
    acc_rnd = acc_sum + AccW'(32);
`else
    acc_rnd = acc_sum;
`endif
    avg = acc_rnd[AccW-1:6];
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ch_q        <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ch_q       <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          if (bus.in_valid) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
              out_data_q  <= avg;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StOut;
            end
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (ch_q == LastCh) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              ch_q       <= ch_q + 8'd1;
              acc_q      <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b1;
              state_q    <= StAccum;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = ch_q;

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter CHANNELS, default 4: channels pooled per job, each channel is one 8x8 window (range 1..256).
REQ-002 Parameter DATA_W, default 16: pixel and result width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle job request, sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse at job end.
REQ-008 in_valid  input  1  pixel beat offered.
REQ-009 in_ready  output  1  controller accepts a pixel this cycle.
REQ-010 in_data  input  DATA_W  unsigned pixel.
REQ-011 out_valid  output  1  pooled result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  DATA_W  channel average.
REQ-014 out_ch  output  8  index of the channel reported on out_data.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCUM, OUT and DONE.
REQ-016 IDLE: start=1 SHALL clear the accumulator, beat counter (6 bit) and channel index, then enter ACCUM.
REQ-017 start SHALL be ignored in ACCUM, OUT and DONE.
REQ-018 ACCUM: in_ready=1, and each in_valid&in_ready beat SHALL add zero-extended in_data to a DATA_W+6 bit accumulator and increment the counter.
REQ-019 The accumulator SHALL never overflow; 64 beats of 0xFFFF SHALL sum exactly.
REQ-020 On acceptance of beat 64 (counter=63), the FSM SHALL enter OUT and register out_data = final sum >> 6, including that beat.
REQ-021 Latency SHALL be one cycle: out_valid rises in the cycle after beat 64 is accepted.
REQ-022 OUT: out_valid=1 and in_ready=0; out_data and out_ch SHALL hold stable until out_valid&out_ready.
REQ-023 On the OUT handshake with out_ch<CHANNELS-1: increment the channel, clear the accumulator and counter, and return to ACCUM.
REQ-024 On the OUT handshake with out_ch=CHANNELS-1: enter DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Idle cycles (in_valid=0) in ACCUM SHALL leave all state unchanged; there is no timeout.
REQ-027 in_ready SHALL be 0 in IDLE, OUT and DONE; beats offered there are not consumed.
REQ-028 With CHANNELS=1, OUT SHALL go directly to DONE after one result.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, regardless of clk.
REQ-030 rst=1 SHALL zero the accumulator, counter, channel index, out_data and out_ch.
REQ-031 Reset values of the flags SHALL be busy=0, done=0, in_ready=0, out_valid=0.
REQ-032 Reset mid-job SHALL discard the partial sum; no result or done pulse SHALL follow.
REQ-033 After reset deassertion, the next start SHALL begin a clean job.

Configuration
REQ-034 Macro POOL_ROUND_EN defined: out_data SHALL be (sum + 32) >> 6, i.e. round-half-up.
REQ-035 Macro POOL_ROUND_EN undefined: out_data SHALL be sum >> 6, i.e. truncation.
REQ-036 The rounding add SHALL not overflow the DATA_W+6 accumulator width.

Verification
REQ-037 CHANNELS=1, 64 beats of 100 -> out_data=100, out_ch=0, then done pulse.
REQ-038 Beats 0..63 (sum 2016) -> out_data=31 without the macro, 32 with POOL_ROUND_EN.
REQ-039 64 beats of 0xFFFF -> out_data=0xFFFF in both configurations (no wrap).
REQ-040 CHANNELS=3, channels of constants 10/20/30, out_ready low 5 cycles per result -> out_data stable while stalled; results 10/20/30 with out_ch 0/1/2; in_ready=0 during OUT; single done.
REQ-041 rst asserted after 40 beats, then start and 64 beats of 7 -> only result 7; no stale output.
REQ-042 in_valid toggled randomly in ACCUM, start pulsed while busy -> sum unaffected and start ignored.
